// File: rtl/neurosync_pkg.sv
// Shared definitions for the neurosync controller: UC state codes, question opcodes
// and the UC control bundle with its Moore decode.
package neurosync_pkg;

  typedef enum logic [3:0] {
    ST_INICIAL      = 4'd0,
    ST_PREPARA      = 4'd1,
    ST_ESCOLHE_MODO = 4'd2,
    ST_REGISTRA     = 4'd3,
    ST_PREP_JOGO    = 4'd4,
    ST_SET_POS      = 4'd5,
    ST_ESPERA_PLAY  = 4'd6,
    ST_ESPERA_FAIXA = 4'd7,
    ST_ACERTO       = 4'd8,
    ST_PROX         = 4'd9,
    ST_ERRO         = 4'd10,
    ST_GANHOU       = 4'd11,
    ST_PERDEU       = 4'd12
  } state_t;

  localparam logic [1:0] OP_BOTOES = 2'b00;
  localparam logic [1:0] OP_SERVO  = 2'b01;
  localparam logic [1:0] OP_FAIXA  = 2'b10;
  localparam logic [1:0] OP_LIVRE  = 2'b11;

  typedef struct packed {
    logic zera;
    logic registra_modo;
    logic zera_prep_jogo;
    logic set_pos;
    logic conta_pergunta;
    logic jogando;
    logic medir;
    logic enable_mov;
    logic show_leds_servo;
    logic zera_idle;
    logic conta_idle;
    logic win;
    logic pronto;
  } uc_ctrl_t;

  // Moore output decode for a given state; opcode only matters in ESPERA_PLAY.
  function automatic uc_ctrl_t decode_ctrl(input state_t st, input logic [1:0] opcode);
    uc_ctrl_t c;
    c = '0;
    case (st)
      ST_PREPARA: begin
        c.zera      = 1'b1;
        c.zera_idle = 1'b1;
      end
      ST_ESCOLHE_MODO: begin
        c.enable_mov      = 1'b1;
        c.show_leds_servo = 1'b1;
      end
      ST_REGISTRA: c.registra_modo = 1'b1;
      ST_PREP_JOGO: begin
        c.zera_prep_jogo = 1'b1;
        c.zera_idle      = 1'b1;
      end
      ST_SET_POS: begin
        c.set_pos         = 1'b1;
        c.jogando         = 1'b1;
        c.show_leds_servo = 1'b1;
      end
      ST_ESPERA_PLAY: begin
        c.jogando         = 1'b1;
        c.show_leds_servo = 1'b1;
        c.enable_mov      = (opcode == OP_SERVO);
      end
      ST_ESPERA_FAIXA: begin
        c.jogando    = 1'b1;
        c.medir      = 1'b1;
        c.conta_idle = 1'b1;
      end
      ST_ACERTO: c.jogando = 1'b1;
      ST_PROX:   c.conta_pergunta = 1'b1;
      ST_GANHOU: begin
        c.win    = 1'b1;
        c.pronto = 1'b1;
      end
      ST_PERDEU: c.pronto = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge pulse generator; the first cycle after reset is masked so a level
// already high at reset release does not count as an edge.
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic pulso_c
);

  logic prev_q, prev_d;
  logic armed_q, armed_d;

  always_comb begin
    prev_d  = sinal;
    armed_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  assign pulso_c = armed_q & sinal & ~prev_q;

endmodule

// File: rtl/neurosync_controller_single_uc.sv
// Control unit for neurosync_controller_single_fd: mode select, 8 questions with a
// lives counter, then GANHOU or PERDEU. Outputs are registered alongside the state.
module neurosync_controller_single_uc
  import neurosync_pkg::*;
#(
  parameter int unsigned N_VIDAS = 3,
  parameter int unsigned VIDAS_W = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               jogar,
  input  logic               confirma,
  input  logic               pronto_play,
  input  logic               acertou_play,
  input  logic               acertou_faixa,
  input  logic               fim_idle,
  input  logic [1:0]         opcode,
  input  logic               is_ultima_pergunta,
  output logic               zera,
  output logic               registra_modo,
  output logic               zera_prep_jogo,
  output logic               set_pos,
  output logic               conta_pergunta,
  output logic               jogando,
  output logic               medir,
  output logic               enable_mov,
  output logic               show_leds_servo,
  output logic               zera_idle,
  output logic               conta_idle,
  output logic               win,
  output logic               pronto,
  output logic [VIDAS_W-1:0] vidas,
  output logic [3:0]         db_estado
);

  state_t               state_q, state_d;
  uc_ctrl_t             ctrl_q, ctrl_d;
  logic [VIDAS_W-1:0]   vidas_q, vidas_d;
  logic                 jogar_p, confirma_p;

  edge_detector u_ed_jogar (
    .clock   (clock),
    .reset   (reset),
    .sinal   (jogar),
    .pulso_c (jogar_p)
  );

  edge_detector u_ed_confirma (
    .clock   (clock),
    .reset   (reset),
    .sinal   (confirma),
    .pulso_c (confirma_p)
  );

  // Next state, lives bookkeeping and the output bundle that goes with the next state.
  always_comb begin
    state_d = state_q;
    vidas_d = vidas_q;
    case (state_q)
      ST_INICIAL:      if (jogar_p) state_d = ST_PREPARA;
      ST_PREPARA:      state_d = ST_ESCOLHE_MODO;
      ST_ESCOLHE_MODO: if (confirma_p) state_d = ST_REGISTRA;
      ST_REGISTRA:     state_d = ST_PREP_JOGO;
      ST_PREP_JOGO:    state_d = ST_SET_POS;
      ST_SET_POS: begin
        case (opcode)
          OP_FAIXA: state_d = ST_ESPERA_FAIXA;
          OP_LIVRE: state_d = ST_ACERTO;
          default:  state_d = ST_ESPERA_PLAY;
        endcase
      end
      ST_ESPERA_PLAY:  if (pronto_play) state_d = acertou_play ? ST_ACERTO : ST_ERRO;
      ST_ESPERA_FAIXA: begin
        if (acertou_faixa)  state_d = ST_ACERTO;
        else if (fim_idle)  state_d = ST_ERRO;
      end
      ST_ACERTO:       state_d = is_ultima_pergunta ? ST_GANHOU : ST_PROX;
      ST_PROX:         state_d = ST_PREP_JOGO;
      ST_ERRO:         state_d = (vidas_q <= VIDAS_W'(1)) ? ST_PERDEU : ST_PREP_JOGO;
      ST_GANHOU:       if (jogar_p) state_d = ST_PREPARA;
      ST_PERDEU:       if (jogar_p) state_d = ST_PREPARA;
      default:         state_d = ST_INICIAL;
    endcase

    // Reload as PREPARA is entered so the fresh count is visible during PREPARA.
    if (state_d == ST_PREPARA) begin
      vidas_d = VIDAS_W'(N_VIDAS);
    end else if (state_q == ST_ERRO && vidas_q != '0) begin
      vidas_d = vidas_q - VIDAS_W'(1);
    end

    ctrl_d = decode_ctrl(state_d, opcode);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_INICIAL;
      ctrl_q  <= '0;
      vidas_q <= VIDAS_W'(N_VIDAS);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      vidas_q <= vidas_d;
    end
  end

  assign zera            = ctrl_q.zera;
  assign registra_modo   = ctrl_q.registra_modo;
  assign zera_prep_jogo  = ctrl_q.zera_prep_jogo;
  assign set_pos         = ctrl_q.set_pos;
  assign conta_pergunta  = ctrl_q.conta_pergunta;
  assign jogando         = ctrl_q.jogando;
  assign medir           = ctrl_q.medir;
  assign enable_mov      = ctrl_q.enable_mov;
  assign show_leds_servo = ctrl_q.show_leds_servo;
  assign zera_idle       = ctrl_q.zera_idle;
  assign conta_idle      = ctrl_q.conta_idle;
  assign win             = ctrl_q.win;
  assign pronto          = ctrl_q.pronto;
  assign vidas           = vidas_q;
  assign db_estado       = state_q;

endmodule
